// File: rtl/capture_pkg.sv
// -----------------------------------------------------------------------------
// capture_pkg
// Shared types and constants for the capture controller:
//   cap_state_t : capture state machine encoding
//   DEC_CNT_W   : width of the decimation strobe counter
//   dec_limit() : terminal count of the decimation counter for a given exponent
// -----------------------------------------------------------------------------
package capture_pkg;

    localparam int DEC_CNT_W = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFILL,
        ST_ARMED,
        ST_POST,
        ST_DONE
    } cap_state_t;

    // 2^pwr - 1, computed one bit wider so pwr = 15 yields all ones.
    function automatic logic [DEC_CNT_W-1:0] dec_limit(input logic [3:0] pwr);
        logic [DEC_CNT_W:0] one_hot;
        one_hot = (DEC_CNT_W+1)'(1) << pwr;
        return DEC_CNT_W'(one_hot - (DEC_CNT_W+1)'(1));
    endfunction

endpackage

// File: rtl/trig_edge_det.sv
// -----------------------------------------------------------------------------
// trig_edge_det
// Selects one trigger channel, registers its level and flags the chosen edge.
// Ports:
//   clk, rst    : system clock, asynchronous active-high reset
//   trig_in     : per-channel trigger levels (synchronous)
//   src         : channel select; out-of-range values never produce a pulse
//   pos_edge    : 1 = rising edge, 0 = falling edge
//   edge_pulse  : one-cycle pulse, high the cycle after the edge is registered
// -----------------------------------------------------------------------------
module trig_edge_det #(
    parameter int NUM_CH = 3,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] trig_in,
    input  logic [CH_W-1:0]   src,
    input  logic              pos_edge,
    output logic              edge_pulse
);

    logic sel_lvl;
    logic src_ok;
    logic lvl_q, lvl_d;
    logic lvl_prev_q, lvl_prev_d;

    always_comb begin
        sel_lvl = 1'b0;
        src_ok  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (src == CH_W'(i)) begin
                sel_lvl = trig_in[i];
                src_ok  = 1'b1;
            end
        end
        lvl_d      = sel_lvl;
        lvl_prev_d = lvl_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q      <= 1'b0;
            lvl_prev_q <= 1'b0;
        end else begin
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_prev_d;
        end
    end

    // A transition is seen between the two registered samples; its direction
    // must match the selected polarity.
    assign edge_pulse = src_ok & (lvl_q ^ lvl_prev_q) & (lvl_q == pos_edge);

endmodule

// File: rtl/capture_ctrl_mc.sv
// -----------------------------------------------------------------------------
// capture_ctrl_mc
// Decimating capture controller feeding a circular trace RAM: pre-trigger
// fill, selectable-edge trigger on one of NUM_CH channels, programmable
// post-trigger length, result held until acknowledged.
// Ports:
//   clk, rst        : system clock, asynchronous active-high reset
//   start, stop     : capture start (IDLE only) / abort to IDLE (stop wins)
//   smpl_vld        : one strobe per ADC sample
//   trig_in         : per-channel trigger levels
//   trig_src        : trigger channel select (latched on start)
//   trig_pos_edge   : 1 rising / 0 falling trigger edge (latched on start)
//   autoroll        : first kept sample in ARMED is the trigger
//   dec_pwr         : keep 1 of every 2^dec_pwr strobes (latched on start)
//   trig_pos        : samples stored after the trigger (latched on start)
//   clr_done        : acknowledges capture_done
//   we, waddr       : registered trace RAM write port
//   armed           : PREFILL / ARMED / POST
//   triggered       : trigger accepted, until back in IDLE
//   capture_done    : result held in DONE
//   trace_end       : address of the last written sample
// -----------------------------------------------------------------------------
module capture_ctrl_mc #(
    parameter int ADDR_W = 9,
    parameter int NUM_CH = 3,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              smpl_vld,
    input  logic [NUM_CH-1:0] trig_in,
    input  logic [CH_W-1:0]   trig_src,
    input  logic              trig_pos_edge,
    input  logic              autoroll,
    input  logic [3:0]        dec_pwr,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic              clr_done,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic              armed,
    output logic              triggered,
    output logic              capture_done,
    output logic [ADDR_W-1:0] trace_end
);

    import capture_pkg::*;

    cap_state_t           state_q, state_d;
    logic [3:0]           dec_pwr_q, dec_pwr_d;
    logic [ADDR_W-1:0]    trig_pos_q, trig_pos_d;
    logic [CH_W-1:0]      trig_src_q, trig_src_d;
    logic                 pos_edge_q, pos_edge_d;
    logic [DEC_CNT_W-1:0] dec_cnt_q, dec_cnt_d;
    logic [ADDR_W-1:0]    cnt_q, cnt_d;
    logic                 trig_pend_q, trig_pend_d;
    logic [ADDR_W-1:0]    ptr_q, ptr_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    waddr_q, waddr_d;
    logic                 armed_q, armed_d;
    logic                 triggered_q, triggered_d;
    logic                 capture_done_q, capture_done_d;
    logic [ADDR_W-1:0]    trace_end_q, trace_end_d;

    logic                 edge_pulse;
    logic                 keep;
    logic                 active;
    logic                 write;
    logic [ADDR_W-1:0]    cnt_inc;

    trig_edge_det #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_edge (
        .clk        (clk),
        .rst        (rst),
        .trig_in    (trig_in),
        .src        (trig_src_q),
        .pos_edge   (pos_edge_q),
        .edge_pulse (edge_pulse)
    );

    always_comb begin
        state_d        = state_q;
        dec_pwr_d      = dec_pwr_q;
        trig_pos_d     = trig_pos_q;
        trig_src_d     = trig_src_q;
        pos_edge_d     = pos_edge_q;
        dec_cnt_d      = dec_cnt_q;
        cnt_d          = cnt_q;
        trig_pend_d    = trig_pend_q;
        ptr_d          = ptr_q;
        we_d           = 1'b0;
        waddr_d        = waddr_q;
        triggered_d    = triggered_q;
        trace_end_d    = trace_end_q;
        write          = 1'b0;
        cnt_inc        = cnt_q + ADDR_W'(1);

        active = (state_q == ST_PREFILL) || (state_q == ST_ARMED) || (state_q == ST_POST);
        keep   = smpl_vld && (dec_cnt_q == dec_limit(dec_pwr_q));

        if (active && smpl_vld) begin
            dec_cnt_d = keep ? '0 : dec_cnt_q + DEC_CNT_W'(1);
        end

        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        dec_pwr_d   = dec_pwr;
                        trig_pos_d  = trig_pos;
                        trig_src_d  = trig_src;
                        pos_edge_d  = trig_pos_edge;
                        dec_cnt_d   = '0;
                        cnt_d       = '0;
                        trig_pend_d = 1'b0;
                        // Pre-fill length is DEPTH-1-trig_pos, i.e. ~trig_pos.
                        state_d     = (trig_pos == '1) ? ST_ARMED : ST_PREFILL;
                    end
                end
                ST_PREFILL: begin
                    if (keep) begin
                        write = 1'b1;
                        cnt_d = cnt_inc;
                        if (cnt_inc == ~trig_pos_q) begin
                            state_d = ST_ARMED;
                        end
                    end
                end
                ST_ARMED: begin
                    if (keep) begin
                        write = 1'b1;
                    end
                    if (keep && (trig_pend_q || autoroll)) begin
                        trig_pend_d = 1'b0;
                        triggered_d = 1'b1;
                        cnt_d       = '0;
                        if (trig_pos_q == '0) begin
                            state_d     = ST_DONE;
                            trace_end_d = ptr_q;
                        end else begin
                            state_d = ST_POST;
                        end
                    end else if (edge_pulse) begin
                        trig_pend_d = 1'b1;
                    end
                end
                ST_POST: begin
                    if (keep) begin
                        write = 1'b1;
                        cnt_d = cnt_inc;
                        if (cnt_inc == trig_pos_q) begin
                            state_d     = ST_DONE;
                            trace_end_d = ptr_q;
                        end
                    end
                end
                ST_DONE: begin
                    if (clr_done) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (write) begin
            we_d    = 1'b1;
            waddr_d = ptr_q;
            ptr_d   = ptr_q + ADDR_W'(1);
        end

        armed_d = (state_d == ST_PREFILL) || (state_d == ST_ARMED) || (state_d == ST_POST);
        if (state_d == ST_IDLE) begin
            triggered_d = 1'b0;
        end
        // Delayed by one cycle so it rises after the final we pulse.
        capture_done_d = (state_q == ST_DONE) && (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            dec_pwr_q      <= '0;
            trig_pos_q     <= '0;
            trig_src_q     <= '0;
            pos_edge_q     <= 1'b0;
            dec_cnt_q      <= '0;
            cnt_q          <= '0;
            trig_pend_q    <= 1'b0;
            ptr_q          <= '0;
            we_q           <= 1'b0;
            waddr_q        <= '0;
            armed_q        <= 1'b0;
            triggered_q    <= 1'b0;
            capture_done_q <= 1'b0;
            trace_end_q    <= '0;
        end else begin
            state_q        <= state_d;
            dec_pwr_q      <= dec_pwr_d;
            trig_pos_q     <= trig_pos_d;
            trig_src_q     <= trig_src_d;
            pos_edge_q     <= pos_edge_d;
            dec_cnt_q      <= dec_cnt_d;
            cnt_q          <= cnt_d;
            trig_pend_q    <= trig_pend_d;
            ptr_q          <= ptr_d;
            we_q           <= we_d;
            waddr_q        <= waddr_d;
            armed_q        <= armed_d;
            triggered_q    <= triggered_d;
            capture_done_q <= capture_done_d;
            trace_end_q    <= trace_end_d;
        end
    end

    assign we           = we_q;
    assign waddr        = waddr_q;
    assign armed        = armed_q;
    assign triggered    = triggered_q;
    assign capture_done = capture_done_q;
    assign trace_end    = trace_end_q;

endmodule

// File: tb/tb_capture_ctrl_mc.sv
module tb_capture_ctrl_mc;

    localparam int AW    = 4;
    localparam int NCH   = 3;
    localparam int CHW   = 2;
    localparam int DEPTH = 16;

    logic           clk;
    logic           rst;
    logic           start, stop, smpl_vld, clr_done;
    logic [NCH-1:0] trig_in;
    logic [CHW-1:0] trig_src;
    logic           trig_pos_edge, autoroll;
    logic [3:0]     dec_pwr;
    logic [AW-1:0]  trig_pos;
    logic           we, armed, triggered, capture_done;
    logic [AW-1:0]  waddr, trace_end;

    int n_chk  = 0;
    int n_pass = 0;
    int we_cnt = 0;

    capture_ctrl_mc #(.ADDR_W(AW), .NUM_CH(NCH), .CH_W(CHW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .smpl_vld      (smpl_vld),
        .trig_in       (trig_in),
        .trig_src      (trig_src),
        .trig_pos_edge (trig_pos_edge),
        .autoroll      (autoroll),
        .dec_pwr       (dec_pwr),
        .trig_pos      (trig_pos),
        .clr_done      (clr_done),
        .we            (we),
        .waddr         (waddr),
        .armed         (armed),
        .triggered     (triggered),
        .capture_done  (capture_done),
        .trace_end     (trace_end)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Tracks a capture as counts: strobes since start, samples kept since
    // start, and the kept-sample index at which the trigger was taken.
    bit            m_active, m_done, m_trig, m_pend, m_we, m_cd;
    int            m_strobes, m_kept, m_trig_idx, m_pre;
    logic [AW-1:0] m_ptr, m_waddr, m_tend, m_tp;
    logic [CHW-1:0] m_src;
    logic [3:0]    m_dp;
    bit            m_pos, m_lvl1, m_lvl2;

    task automatic model_step();
        bit edge_now, armed_before, fire, done_before;
        if (rst) begin
            m_active = 0; m_done = 0; m_trig = 0; m_pend = 0; m_we = 0; m_cd = 0;
            m_strobes = 0; m_kept = 0; m_trig_idx = -1; m_pre = 0;
            m_ptr = '0; m_waddr = '0; m_tend = '0; m_tp = '0;
            m_src = '0; m_dp = '0; m_pos = 0; m_lvl1 = 0; m_lvl2 = 0;
            return;
        end
        done_before  = m_done;
        edge_now     = (int'(m_src) < NCH) && (m_lvl1 != m_lvl2) && (m_lvl1 == m_pos);
        m_lvl2       = m_lvl1;
        m_lvl1       = (int'(m_src) < NCH) ? trig_in[m_src] : 1'b0;
        armed_before = m_active && (m_kept >= m_pre) && (m_trig_idx < 0);
        fire = 0;
        m_we = 0;
        if (stop) begin
            m_active = 0; m_done = 0; m_trig = 0;
        end else if (m_done) begin
            if (clr_done) begin m_done = 0; m_trig = 0; end
        end else if (!m_active) begin
            if (start) begin
                m_dp = dec_pwr; m_tp = trig_pos; m_src = trig_src; m_pos = trig_pos_edge;
                m_active = 1; m_strobes = 0; m_kept = 0; m_pend = 0; m_trig_idx = -1;
                m_pre = DEPTH - 1 - int'(trig_pos);
            end
        end else if (smpl_vld) begin
            m_strobes++;
            if (m_strobes % (1 << m_dp) == 0) begin
                m_we = 1;
                m_waddr = m_ptr;
                if (m_kept >= m_pre && m_trig_idx < 0 && (m_pend || autoroll)) begin
                    m_trig_idx = m_kept; m_trig = 1; fire = 1;
                end
                if (m_trig_idx >= 0 && (m_kept - m_trig_idx) == int'(m_tp)) begin
                    m_done = 1; m_active = 0; m_tend = m_ptr;
                end
                m_kept++;
                m_ptr = m_ptr + 1'b1;
            end
        end
        if (fire) m_pend = 0;
        else if (armed_before && edge_now) m_pend = 1;
        m_cd = done_before && m_done;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            check("we", int'(we), int'(m_we));
            if (m_we) check("waddr", int'(waddr), int'(m_waddr));
            check("armed", int'(armed), int'(m_active));
            check("triggered", int'(triggered), int'(m_trig));
            check("capture_done", int'(capture_done), int'(m_cd));
            if (m_cd) check("trace_end", int'(trace_end), int'(m_tend));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic sv, input logic st, input logic sp, input logic clr);
        smpl_vld = sv; start = st; stop = sp; clr_done = clr;
        @(negedge clk);
        if (we) we_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0);
    endtask

    task automatic cfg(input logic [3:0] dp, input logic [AW-1:0] tp, input logic [CHW-1:0] src,
                       input logic pe, input logic ar);
        dec_pwr = dp; trig_pos = tp; trig_src = src; trig_pos_edge = pe; autoroll = ar;
    endtask

    initial begin
        rst = 1'b1; start = 0; stop = 0; smpl_vld = 0; clr_done = 0; trig_in = '0;
        cfg(4'd0, 4'd4, 2'd1, 1'b1, 1'b0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("rst_we", int'(we), 0);
        check("rst_waddr", int'(waddr), 0);
        check("rst_armed", int'(armed), 0);
        check("rst_trace_end", int'(trace_end), 0);
        rst = 1'b0;
        step(0, 0, 0, 0);

        // 1: rising edge on ch1 at sample 20; pre-fill 11, trigger sample 22
        we_cnt = 0;
        step(0, 1, 0, 0);
        run(11);
        check("t1_prefill_writes", we_cnt, 11);
        check("t1_prefill_last_addr", int'(waddr), 10);
        run(8);
        trig_in[1] = 1'b1;
        run(7);
        step(0, 0, 0, 0);
        check("t1_done", int'(capture_done), 1);
        check("t1_trace_end", int'(trace_end), 9);
        check("t1_total_writes", we_cnt, 26);
        step(0, 1, 0, 0);
        check("t1_start_in_done", int'(capture_done), 1);
        step(0, 0, 0, 1);
        check("t1_clr_done", int'(capture_done), 0);
        check("t1_clr_trig", int'(triggered), 0);
        trig_in = '0;

        // 2: decimation by 4, 32 strobes -> 8 writes at 10..15,0,1
        cfg(4'd2, 4'd4, 2'd1, 1'b1, 1'b0);
        we_cnt = 0;
        step(0, 1, 0, 0);
        run(32);
        check("t2_writes", we_cnt, 8);
        check("t2_wrap_addr", int'(waddr), 1);
        step(0, 0, 1, 0);

        // 3: autoroll, trig_pos=0 -> trigger on first kept sample after pre-fill
        cfg(4'd0, 4'd0, 2'd1, 1'b1, 1'b1);
        we_cnt = 0;
        step(0, 1, 0, 0);
        run(16);
        check("t3_triggered", int'(triggered), 1);
        step(0, 0, 0, 0);
        check("t3_done", int'(capture_done), 1);
        check("t3_trace_end", int'(trace_end), 1);
        check("t3_writes", we_cnt, 16);
        step(0, 0, 0, 1);

        // 4: falling edge on ch2; ignored in PREFILL, ch0 ignored in ARMED
        cfg(4'd0, 4'd4, 2'd2, 1'b0, 1'b0);
        trig_in = 3'b111;
        we_cnt = 0;
        step(0, 1, 0, 0);
        run(2);
        trig_in[2] = 1'b0;
        run(3);
        trig_in[2] = 1'b1;
        run(8);
        trig_in[0] = 1'b0;
        run(8);
        check("t4_no_trigger", int'(triggered), 0);
        trig_in[2] = 1'b0;
        run(7);
        step(0, 0, 0, 0);
        check("t4_done", int'(capture_done), 1);
        check("t4_trace_end", int'(trace_end), 13);
        check("t4_writes", we_cnt, 28);
        step(0, 0, 0, 1);
        trig_in = '0;

        // 5: stop during POST, write in the stop cycle suppressed, restart
        cfg(4'd0, 4'd4, 2'd1, 1'b1, 1'b1);
        we_cnt = 0;
        step(0, 1, 0, 0);
        run(14);
        check("t5_writes_before_stop", we_cnt, 14);
        we_cnt = 0;
        step(1, 0, 1, 0);
        run(5);
        check("t5_no_we_after_stop", we_cnt, 0);
        check("t5_done_low", int'(capture_done), 0);
        check("t5_armed_low", int'(armed), 0);
        step(0, 1, 0, 0);
        run(16);
        step(0, 0, 0, 0);
        check("t5_restart_done", int'(capture_done), 1);
        step(0, 0, 0, 1);

        // 6: reset in ARMED, then clr_done in IDLE
        cfg(4'd0, 4'd4, 2'd1, 1'b1, 1'b0);
        step(0, 1, 0, 0);
        run(14);
        rst = 1'b1;
        step(1, 0, 0, 0);
        check("t6_rst_we", int'(we), 0);
        check("t6_rst_waddr", int'(waddr), 0);
        check("t6_rst_armed", int'(armed), 0);
        check("t6_rst_trig", int'(triggered), 0);
        check("t6_rst_done", int'(capture_done), 0);
        check("t6_rst_trace_end", int'(trace_end), 0);
        rst = 1'b0;
        step(0, 0, 0, 1);
        check("t6_clr_idle_done", int'(capture_done), 0);
        check("t6_clr_idle_armed", int'(armed), 0);
        we_cnt = 0;
        run(3);
        check("t6_idle_no_we", we_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/capture_ctrl_mc.md
# capture_ctrl_mc

Parametrised multi-channel capture controller for the scope acquisition path. It decimates a sample-valid stream by 2^dec_pwr and writes kept samples into a circular trace RAM of 2^ADDR_W entries. It guarantees a pre-trigger fill and detects a selectable-edge trigger on one of NUM_CH channels. It then stores a programmable number of post-trigger samples and holds the result until software acknowledges it. It sits between the ADC sample strobe and the trace RAM write port; the command/UART logic drives its controls.

## Interface
- ADDR_W, 9: trace RAM address width; DEPTH = 2^ADDR_W.
- NUM_CH, 3: number of trigger-capable channels.
- CH_W, $clog2(NUM_CH) (min 1): width of the trigger source select.
- clk  in  1  single system clock, all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; begins a capture; accepted only in IDLE.
- stop  in  1  one-cycle pulse; aborts from any state to IDLE; done is not set.
- smpl_vld  in  1  one-cycle strobe per ADC sample.
- trig_in  in  NUM_CH  synchronous per-channel trigger levels.
- trig_src  in  CH_W  channel select for the trigger; values ≥ NUM_CH never trigger.
- trig_pos_edge  in  1  1 = rising-edge trigger, 0 = falling-edge trigger.
- autoroll  in  1  1 = the first kept sample in ARMED is treated as the trigger.
- dec_pwr  in  4  decimation exponent; keep 1 of every 2^dec_pwr strobes.
- trig_pos  in  ADDR_W  number of samples stored after the trigger sample.
- clr_done  in  1  acknowledges capture_done.
- we  out  1  trace RAM write enable, registered.
- waddr  out  ADDR_W  trace RAM write address, registered.
- armed  out  1  high in PREFILL, ARMED and POST.
- triggered  out  1  high from trigger acceptance until the return to IDLE.
- capture_done  out  1  high in DONE.
- trace_end  out  ADDR_W  address of the last sample written; valid while capture_done is high.

## Operation
- States are IDLE, PREFILL, ARMED, POST and DONE.
- On start, the block latches dec_pwr, trig_pos, trig_src and trig_pos_edge. It clears the decimation counter, the pre/post counter and the pending-trigger flag. waddr is not reset; the buffer is circular.
- Keep rule: each smpl_vld increments dec_cnt (15 bit). A sample is kept when dec_cnt == 2^dec_pwr−1, and dec_cnt then clears. With dec_pwr=0 every strobe is kept.
- PREFILL: writes kept samples until (DEPTH−1−trig_pos) samples are stored, then moves to ARMED. If that count is 0, start goes directly to ARMED.
- Edge detect: trig_in[trig_src] is registered every clk. A qualifying edge sets trig_pend while in ARMED; edges outside ARMED are ignored.
- ARMED: each kept sample is written. A kept sample that coincides with trig_pend, or any kept sample when autoroll=1, is the trigger sample. That sample is written, trig_pend is cleared, triggered is set and the state moves to POST with post_cnt=0.
- POST: each kept sample is written and post_cnt increments. When post_cnt reaches trig_pos after a write, trace_end is set to that write's address and the state moves to DONE. With trig_pos=0 the trigger sample itself ends the capture and goes straight to DONE.
- DONE: no writes. clr_done moves the state to IDLE. start is ignored until the block is back in IDLE.

## Timing
- Reset values: state=IDLE; we=0, waddr=0, armed=0, triggered=0, capture_done=0, trace_end=0, all internal counters 0.
- Write latency: kept sample at cycle N gives we=1 at N+1 with waddr equal to the current pointer. The pointer increments at N+1 and wraps DEPTH−1→0.
- Trigger latency: an edge at cycle N is registered at N+1. It is usable by any kept sample at N+2 or later.
- capture_done rises one cycle after the final write's we pulse.
- stop and start in the same cycle: stop wins.
- stop in the same cycle as a kept sample: the write is suppressed.
- clr_done outside DONE has no effect.
- Changes to the configuration inputs mid-capture have no effect until the next start.
- rst asserted mid-capture clears everything immediately; no further we pulses occur.

## Structure
- Package capture_pkg holds the state enum typedef (cap_state_t) and the dec_cnt width constant DEC_CNT_W=15.
- Sub-module trig_edge_det contains the channel mux, the level register and the edge select, and outputs a one-cycle edge pulse.

## Test plan
1. ADDR_W=4, trig_pos=4, dec_pwr=0, smpl_vld every cycle, rising edge on ch1 after 20 samples → exactly 11 PREFILL writes, then ARMED writes, trigger sample, 4 post writes; trace_end = last waddr; capture_done set.
2. dec_pwr=2, smpl_vld every cycle → we pulses every 4th strobe only; waddr increments by 1 per pulse and wraps 15→0.
3. autoroll=1, no trig_in activity, trig_pos=0 → trigger occurs on the first kept sample after PREFILL; DONE reached on that same write.
4. Falling-edge mode, edge on ch2 during PREFILL and on ch0 (not selected) during ARMED → no trigger; a later ch2 falling edge triggers.
5. stop during POST → return to IDLE, capture_done stays 0, no further we; a subsequent start works normally.
6. rst pulsed during ARMED → all outputs at reset values next cycle; clr_done pulsed in IDLE has no effect.
